count_display_driver: RTL and testbench
=======================================

Name: count_display_driver

Overview:
- Display-side consumer for the up/down counter: takes a 10-bit binary count (0..999), converts it to 3 BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a 3-digit multiplexed 7-segment display.
- Sits between the counter datapath and the board's segment/anode pins.
- Exposes a load/busy/done handshake so the counter side knows when a new value has been accepted and converted.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays active; minimum 2.
- SEG_ACTIVE_LOW, 1, 1 inverts the seg outputs.
- AN_ACTIVE_LOW, 1, 1 inverts the an outputs.
- BLANK_LZ, 1, 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- value_in  in  10  binary value to display.
- load  in  1  request to convert value_in; sampled only when busy=0.
- busy  out  1  conversion in progress; load is ignored while high.
- done  out  1  one-cycle pulse when bcd updates.
- bcd  out  12  {hundreds,tens,ones}, 4 bits per digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- an  out  3  digit enables, an[0]=ones, one-hot, registered.

Behaviour:
- Reset (rst=1 at posedge), every output and state register:
  - FSM=IDLE; busy=0, done=0; bcd=12'h000; ovf=0.
  - Scan divider=0, digit index=0.
  - an selects digit0; seg = code for "0".
  - Mid-conversion reset aborts the conversion: no done pulse, bcd=0.
- FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, load=1 at edge N:
  - Capture value_in into the shift register and clear the BCD scratch.
  - ovf = (value_in > 999).
  - Iteration counter=0; busy=1 from edge N.
- SHIFT: one iteration per edge, at edges N+1..N+10.
  - Add 3 to each BCD nibble that is >=5, then shift {scratch,bin} left 1.
  - After the 10th iteration (edge N+10), go to DONE.
- DONE (edge N+11):
  - bcd <= scratch, or 12'hFFF if ovf.
  - done=1 for exactly this one cycle; busy=0; state IDLE.
  - A load at this edge is ignored; the first accepted reload is at edge N+12.
- Latency: load edge N -> bcd valid and done high after edge N+11. Throughput: one conversion per 12 cycles.
- load while busy=1 is ignored: no queuing, captured value unchanged.
- The bcd register holds its value between conversions. The display always shows bcd, never scratch.
- Scan:
  - Divider counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, digit index advances 0->1->2->0.
  - seg/an update one cycle after an index change.
- Segment codes (active-high form), digits 0-9:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - dash=40, blank=00.
  - SEG_ACTIVE_LOW inverts all 7 bits; AN_ACTIVE_LOW inverts an.
- Overflow (bcd=FFF): all three digits show dash; blanking does not apply.
- Leading-zero blanking (BLANK_LZ=1):
  - digit2 blank if hundreds=0.
  - digit1 blank if hundreds=0 and tens=0.
  - digit0 never blank.
  - Blanked digit: seg=blank code, an still asserted.
- Nibble values 10-14 cannot occur outside the overflow case; decode them as blank.

Test Plan:
- Reset with SEG/AN_ACTIVE_LOW=1 -> busy=0, done=0, bcd=000, an=3'b110, seg=7'b1000000 (digit "0"); with BLANK_LZ=1, digits 1 and 2 are blank when scanned.
- load=1 with value_in=999 at edge N -> busy high for 11 cycles, done pulse exactly once after edge N+11, bcd=12'h999; repeat for 0 -> 000 and 512 -> 512.
- value_in=105, SCAN_DIV=4 -> an sequence digit0,1,2 every 4 cycles; seg shows 5, 0, 1 (middle zero not blanked); value 7 -> digits 1 and 2 blank, digit0 shows 7.
- value_in=1000 and 1023 -> bcd=12'hFFF, done pulses, all digits show 7'b0111111 (dash, active-low).
- load pulses held during busy (value_in changed to 42 mid-conversion) -> ignored; result equals the first value; a load on the DONE edge is ignored and the next idle edge is accepted.
- rst asserted at iteration 5 -> no done pulse, bcd=000, busy=0 next cycle; a fresh load of 321 then completes normally with bcd=12'h321.

Source files
------------

// File: rtl/count_display_driver.sv
// Binary (0..999) to 3-digit BCD via sequential double-dabble, driving a multiplexed 7-segment display.
// Latency: load accepted at edge N -> bcd/done valid after edge N+11; seg/an lag the scan index by one cycle.
// Backpressure: load is sampled only while busy=0; loads during a conversion are dropped, never queued.
module count_display_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  value_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  // Divider width; SCAN_DIV is at least 2 so a 1-bit counter is the smallest case.
  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Active-high segment codes for the special glyphs.
  localparam logic [6:0] SEG_ZERO  = 7'h3F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Pin-level reset values: digit0 enabled, showing "0".
  localparam logic [6:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [2:0] AN_RST  = (AN_ACTIVE_LOW != 0) ? 3'b110 : 3'b001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Conversion engine state
  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] scratch_q, scratch_d;
  logic [9:0]  bin_q, bin_d;
  logic [3:0]  iter_q, iter_d;

  // Scan / display state
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;

  // Combinational helpers
  logic [11:0] adj;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  seg_raw;
  logic [2:0]  an_raw;

  // Active-high 7-segment code for a decimal nibble; 10..15 never occur for a real digit, show blank.
  function automatic logic [6:0] digit_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

  // Conversion FSM next-state: capture, ten add-3/shift iterations, then publish the result.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    scratch_d = scratch_q;
    bin_d     = bin_q;
    iter_d    = iter_q;
    adj       = scratch_q;

    // Add-3 correction on every BCD nibble that would carry past 9 after doubling.
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d     = value_in;
          scratch_d = 12'h000;
          ovf_d     = (value_in > 10'd999);
          iter_d    = 4'd0;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Shift the corrected scratch and the remaining binary bits left as one 22-bit word.
        {scratch_d, bin_d} = {adj[10:0], bin_q, 1'b0};
        iter_d             = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Out-of-range inputs publish the all-F marker so the display shows dashes.
        bcd_d   = ovf_q ? 12'hFFF : scratch_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Conversion FSM registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= 12'h000;
      scratch_q <= 12'h000;
      bin_q     <= 10'd0;
      iter_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      scratch_q <= scratch_d;
      bin_q     <= bin_d;
      iter_q    <= iter_d;
    end
  end

  // Scan divider and digit index: advance to the next digit each time the divider wraps.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Digit decode for the currently scanned position, from the published bcd only.
  always_comb begin
    case (idx_q)
      2'd0:    nib = bcd_q[3:0];
      2'd1:    nib = bcd_q[7:4];
      2'd2:    nib = bcd_q[11:8];
      default: nib = 4'hF;
    endcase

    // Leading-zero blanking: hundreds blank on 0, tens blank only if hundreds is also 0.
    blank = 1'b0;
    if (BLANK_LZ != 0) begin
      if (idx_q == 2'd2 && bcd_q[11:8] == 4'd0) begin
        blank = 1'b1;
      end
      if (idx_q == 2'd1 && bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) begin
        blank = 1'b1;
      end
    end

    // Overflow wins over blanking so all three digits show a dash.
    if (bcd_q == 12'hFFF) begin
      seg_raw = SEG_DASH;
    end else if (blank) begin
      seg_raw = SEG_BLANK;
    end else begin
      seg_raw = digit_code(nib);
    end

    an_raw = 3'b001 << idx_q;
    seg_d  = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    an_d   = (AN_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
  end

  // Scan and pin registers; seg/an follow the index one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= 2'd0;
      seg_q <= SEG_RST;
      an_q  <= AN_RST;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized and directed bench for count_display_driver, two parameterizations sharing inputs.
// Reference model works on decimal integers and a conversion countdown, checked every cycle.
// All checks funnel through check_eq; the run ends with a single summary line.
module tb_count_display_driver;

  localparam int SD = 4;
  localparam logic [6:0] SEG_TBL [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [9:0]  value_in;

  logic        busy_a, done_a, busy_b, done_b;
  logic [11:0] bcd_a, bcd_b;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  an_a, an_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int mv;      // displayed value, -1 means overflow
  bit m_busy;
  int m_cnt;
  int m_pend;
  bit m_done;
  int k;       // edges since reset
  int m_idx;

  always #5 clk = ~clk;

  count_display_driver #(
    .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LZ(1)
  ) dut_a (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .seg(seg_a), .an(an_a)
  );

  count_display_driver #(
    .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .BLANK_LZ(0)
  ) dut_b (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .seg(seg_b), .an(an_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int val, input int idx, input bit lz, input bit inv);
    logic [6:0] c;
    int d;
    if (val < 0) begin
      c = 7'h40;
    end else begin
      d = (idx == 0) ? val % 10 : (idx == 1) ? (val / 10) % 10 : val / 100;
      if (lz && ((idx == 2 && val < 100) || (idx == 1 && val < 10))) c = 7'h00;
      else c = SEG_TBL[d];
    end
    return inv ? ~c : c;
  endfunction

  function automatic logic [2:0] exp_an(input int idx, input bit inv);
    logic [2:0] a;
    a = 3'b001 << idx;
    return inv ? ~a : a;
  endfunction

  function automatic logic [11:0] exp_bcd(input int val);
    if (val < 0) return 12'hFFF;
    return {4'(val / 100), 4'((val / 10) % 10), 4'(val % 10)};
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input bit r, input bit ld, input int v);
    logic [6:0] sa, sb;
    logic [2:0] aa, ab;
    rst      = r;
    load     = ld;
    value_in = 10'(v);
    @(posedge clk);
    #1;
    if (r) begin
      mv = 0; m_busy = 0; m_cnt = 0; m_done = 0; k = 0;
      sa = exp_seg(0, 0, 1, 1);
      sb = exp_seg(0, 0, 0, 0);
      aa = exp_an(0, 1);
      ab = exp_an(0, 0);
    end else begin
      // Display registers reflect the value and digit position seen before this edge.
      sa = exp_seg(mv, m_idx, 1, 1);
      sb = exp_seg(mv, m_idx, 0, 0);
      aa = exp_an(m_idx, 1);
      ab = exp_an(m_idx, 0);
      m_done = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_done = 1;
          mv = (m_pend > 999) ? -1 : m_pend;
        end
      end else if (ld) begin
        m_busy = 1;
        m_cnt  = 11;
        m_pend = v;
      end
      k++;
    end
    m_idx = (k / SD) % 3;
    check_eq("busy", busy_a, m_busy);
    check_eq("done", done_a, m_done);
    check_eq("bcd", bcd_a, exp_bcd(mv));
    check_eq("seg_lo", seg_a, sa);
    check_eq("an_lo", an_a, aa);
    check_eq("bcd_hi", bcd_b, exp_bcd(mv));
    check_eq("done_hi", done_b, m_done);
    check_eq("seg_hi", seg_b, sb);
    check_eq("an_hi", an_b, ab);
  endtask

  task automatic convert(input int v, input int idle);
    step(0, 1, v);
    for (int i = 0; i < idle; i++) step(0, 0, $urandom_range(0, 1023));
  endtask

  initial begin
    mv = 0; m_busy = 0; m_cnt = 0; m_pend = 0; m_done = 0; k = 0; m_idx = 0;
    step(1, 0, 0);
    step(1, 1, 999);
    for (int i = 0; i < 13; i++) step(0, 0, 0);

    convert(999, 13);
    convert(0, 13);
    convert(512, 13);
    convert(105, 16);
    convert(7, 16);
    convert(1000, 14);
    convert(1023, 14);

    // Loads during busy are dropped; load on the done edge is dropped; the next idle edge is taken.
    step(0, 1, 200);
    for (int i = 0; i < 10; i++) step(0, 1, 42);
    step(0, 1, 55);
    step(0, 1, 66);
    for (int i = 0; i < 13; i++) step(0, 0, 0);

    // Reset in the middle of a conversion, then a clean conversion.
    step(0, 1, 777);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    convert(321, 14);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) step(1, 0, 0);
      else step(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1023));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
